// File: rtl/control_disparo_ultrasonico.sv
// ---------------------------------------------------------------------------
// control_disparo_ultrasonico
// Drives an ultrasonic ranging sensor (HC-SR04 style): fires a trig pulse,
// waits for the echo, measures the echo high time in clk cycles, and repeats
// on a fixed period while habilitar is held high.
//
// Ports
//   clk            system clock, all state on rising edge
//   rst_n          asynchronous active-low reset
//   habilitar      level, requests continuous measurement cycles
//   echo           raw asynchronous echo pin
//   trig           registered trigger pulse to the sensor
//   echo_limpio    synchronized echo (2 flops)
//   ancho_eco      last result in clk cycles (20'hFFFFF on echo timeout)
//   medicion_lista one-cycle pulse, ancho_eco holds a fresh valid width
//   error_pulso    one-cycle pulse on a failed measurement
//   codigo_error   held cause: 01 no echo, 10 echo too long, 11 echo stuck
//   ocupado        high whenever the FSM is not idle
// ---------------------------------------------------------------------------
module control_disparo_ultrasonico #(
    parameter int TRIG_CICLOS       = 500,
    parameter int ESPERA_ECO_CICLOS = 50000,
    parameter int TIMEOUT_CICLOS    = 1000000,
    parameter int PERIODO_CICLOS    = 3000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        habilitar,
    input  logic        echo,
    output logic        trig,
    output logic        echo_limpio,
    output logic [19:0] ancho_eco,
    output logic        medicion_lista,
    output logic        error_pulso,
    output logic [1:0]  codigo_error,
    output logic        ocupado
);

    localparam int PW = $clog2(PERIODO_CICLOS + 1);
    localparam int EW = $clog2(ESPERA_ECO_CICLOS + 1);

    localparam logic [PW-1:0] PER_FIN  = PW'(PERIODO_CICLOS - 1);
    localparam logic [PW-1:0] TRIG_FIN = PW'(TRIG_CICLOS - 1);
    localparam logic [EW-1:0] ESP_FIN  = EW'(ESPERA_ECO_CICLOS - 1);
    localparam logic [19:0]   TMO      = 20'(TIMEOUT_CICLOS);

    localparam logic [1:0] ERR_SIN_ECO   = 2'b01;
    localparam logic [1:0] ERR_ECO_LARGO = 2'b10;
    localparam logic [1:0] ERR_ECO_ALTO  = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        TRIGGER,
        WAIT_RISE,
        MEASURE,
        HOLDOFF
    } estado_t;

    estado_t       estado;
    logic          echo_m, echo_s;
    logic [PW-1:0] cnt_periodo;
    logic [EW-1:0] cnt_espera;
    logic [19:0]   cnt_ancho;

    // Two-flop synchronizer; the FSM only ever looks at echo_s.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            echo_m <= 1'b0;
            echo_s <= 1'b0;
        end else begin
            echo_m <= echo;
            echo_s <= echo_m;
        end
    end

    assign echo_limpio = echo_s;
    assign ocupado     = (estado != IDLE);

    // cnt_periodo is 0 on the first TRIGGER cycle, so trig spans counts
    // 0..TRIG_FIN and the next trigger starts the cycle after PER_FIN,
    // giving a rise-to-rise spacing of exactly PERIODO_CICLOS. It saturates
    // at PER_FIN so a stuck echo stretches the period instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado         <= IDLE;
            trig           <= 1'b0;
            ancho_eco      <= '0;
            medicion_lista <= 1'b0;
            error_pulso    <= 1'b0;
            codigo_error   <= 2'b00;
            cnt_periodo    <= '0;
            cnt_espera     <= '0;
            cnt_ancho      <= '0;
        end else begin
            medicion_lista <= 1'b0;
            error_pulso    <= 1'b0;

            if (estado != IDLE && cnt_periodo != PER_FIN)
                cnt_periodo <= cnt_periodo + 1'b1;

            case (estado)
                IDLE: begin
                    cnt_periodo <= '0;
                    if (habilitar) begin
                        estado <= TRIGGER;
                        trig   <= 1'b1;
                    end
                end

                TRIGGER: begin
                    if (cnt_periodo == TRIG_FIN) begin
                        trig <= 1'b0;
                        if (echo_s) begin
                            // Echo already high before we fired: sensor stuck.
                            error_pulso  <= 1'b1;
                            codigo_error <= ERR_ECO_ALTO;
                            estado       <= HOLDOFF;
                        end else begin
                            cnt_espera <= '0;
                            estado     <= WAIT_RISE;
                        end
                    end
                end

                WAIT_RISE: begin
                    if (echo_s) begin
                        // This cycle already counts as the first high cycle.
                        cnt_ancho <= 20'd1;
                        estado    <= MEASURE;
                    end else if (cnt_espera == ESP_FIN) begin
                        error_pulso  <= 1'b1;
                        codigo_error <= ERR_SIN_ECO;
                        estado       <= HOLDOFF;
                    end else begin
                        cnt_espera <= cnt_espera + 1'b1;
                    end
                end

                MEASURE: begin
                    if (!echo_s) begin
                        ancho_eco      <= cnt_ancho;
                        medicion_lista <= 1'b1;
                        estado         <= HOLDOFF;
                    end else if (cnt_ancho == TMO) begin
                        ancho_eco    <= 20'hFFFFF;
                        error_pulso  <= 1'b1;
                        codigo_error <= ERR_ECO_LARGO;
                        estado       <= HOLDOFF;
                    end else begin
                        cnt_ancho <= cnt_ancho + 1'b1;
                    end
                end

                HOLDOFF: begin
                    // Never fire into a still-high echo; wait it out.
                    if (cnt_periodo == PER_FIN && !echo_s) begin
                        cnt_periodo <= '0;
                        if (habilitar) begin
                            estado <= TRIGGER;
                            trig   <= 1'b1;
                        end else begin
                            estado <= IDLE;
                        end
                    end
                end

                default: begin
                    estado <= IDLE;
                    trig   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_control_disparo_ultrasonico.sv
// ---------------------------------------------------------------------------
// tb_control_disparo_ultrasonico
// Directed scenarios with a scoreboard: the stimulus pushes the expected
// result of each measurement cycle, a monitor pops and compares whenever
// medicion_lista or error_pulso fires. Timing (trig width, period, error
// latency, return to idle) is checked inline by the stimulus.
// ---------------------------------------------------------------------------
module tb_control_disparo_ultrasonico;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        habilitar;
    logic        echo;
    logic        trig;
    logic        echo_limpio;
    logic [19:0] ancho_eco;
    logic        medicion_lista;
    logic        error_pulso;
    logic [1:0]  codigo_error;
    logic        ocupado;

    control_disparo_ultrasonico #(
        .TRIG_CICLOS      (5),
        .ESPERA_ECO_CICLOS(20),
        .TIMEOUT_CICLOS   (100),
        .PERIODO_CICLOS   (300)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .habilitar     (habilitar),
        .echo          (echo),
        .trig          (trig),
        .echo_limpio   (echo_limpio),
        .ancho_eco     (ancho_eco),
        .medicion_lista(medicion_lista),
        .error_pulso   (error_pulso),
        .codigo_error  (codigo_error),
        .ocupado       (ocupado)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic        es_med;
        logic [19:0] ancho;
        logic [1:0]  cod;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp_v, cyc);
        end
    endtask

    task automatic push(input logic es_med, input logic [19:0] a, input logic [1:0] c);
        exp_t e;
        e.es_med = es_med;
        e.ancho  = a;
        e.cod    = c;
        sb.push_back(e);
    endtask

    // Monitor: every result pulse consumes one scoreboard entry.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && (medicion_lista || error_pulso)) begin
            chk("exclusive_pulses", {31'd0, medicion_lista & error_pulso}, 32'd0);
            if (sb.size() == 0) begin
                chk("unexpected_result", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("result_kind", {31'd0, medicion_lista}, {31'd0, e.es_med});
                chk("ancho_eco", {12'd0, ancho_eco}, {12'd0, e.ancho});
                chk("codigo_error", {30'd0, codigo_error}, {30'd0, e.cod});
            end
        end
    end

    task automatic wait_trig(input logic lv, input string nm, output int at);
        at = -1;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (trig === lv) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) chk(nm, 32'd1, 32'd0);
    endtask

    task automatic wait_idle(input string nm, output int at);
        at = -1;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (ocupado === 1'b0) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) chk(nm, 32'd1, 32'd0);
    endtask

    task automatic wait_err(input string nm, output int at);
        at = -1;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (error_pulso === 1'b1) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) chk(nm, 32'd1, 32'd0);
    endtask

    task automatic count_trig(input int n, output int highs);
        highs = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (trig !== 1'b0) highs++;
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_trig"}, {31'd0, trig}, 32'd0);
        chk({tag, "_ancho"}, {12'd0, ancho_eco}, 32'd0);
        chk({tag, "_med"}, {31'd0, medicion_lista}, 32'd0);
        chk({tag, "_err"}, {31'd0, error_pulso}, 32'd0);
        chk({tag, "_cod"}, {30'd0, codigo_error}, 32'd0);
        chk({tag, "_ocupado"}, {31'd0, ocupado}, 32'd0);
        chk({tag, "_echo_limpio"}, {31'd0, echo_limpio}, 32'd0);
    endtask

    initial begin
        int r1, f1, r2, f2, r3, f3, r4, r5, r6, f6, t, h;
        rst_n = 1'b0;
        habilitar = 1'b0;
        echo = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        rst_n = 1'b1;
        count_trig(5, h);
        chk("idle_no_trig", h, 0);

        // 1: clean 37-cycle echo
        push(1'b1, 20'd37, 2'b00);
        habilitar = 1'b1;
        wait_trig(1'b1, "t1_rise_timeout", r1);
        wait_trig(1'b0, "t1_fall_timeout", f1);
        chk("t1_trig_width", f1 - r1, 5);
        repeat (4) @(negedge clk);
        echo = 1'b1;
        repeat (37) @(negedge clk);
        echo = 1'b0;

        // 2: no echo -> code 01, width held at 37
        push(1'b0, 20'd37, 2'b01);
        wait_trig(1'b1, "t2_rise_timeout", r2);
        chk("t1_period", r2 - r1, 300);
        wait_trig(1'b0, "t2_fall_timeout", f2);
        wait_err("t2_err_timeout", t);
        chk("t2_err_latency", t - f2, 20);

        // 3: echo far longer than timeout -> code 10, period stretched
        push(1'b0, 20'hFFFFF, 2'b10);
        wait_trig(1'b1, "t3_rise_timeout", r3);
        chk("t2_period", r3 - r2, 300);
        wait_trig(1'b0, "t3_fall_timeout", f3);
        chk("t3_trig_width", f3 - r3, 5);
        repeat (2) @(negedge clk);
        echo = 1'b1;
        repeat (400) @(negedge clk);
        echo = 1'b0;
        wait_trig(1'b1, "t3_retrig_timeout", r4);
        chk("t3_stretched_period", r4 - r3, 410);

        // habilitar drops right after a trigger: cycle completes, then idle
        habilitar = 1'b0;
        push(1'b0, 20'hFFFFF, 2'b01);
        wait_idle("t3b_idle_timeout", t);
        chk("t3b_idle_at_period", t - r4, 300);
        count_trig(50, h);
        chk("t3b_no_retrig", h, 0);

        // 4: echo already high when fired -> code 11, no measurement
        echo = 1'b1;
        repeat (5) @(negedge clk);
        push(1'b0, 20'hFFFFF, 2'b11);
        habilitar = 1'b1;
        wait_trig(1'b1, "t4_rise_timeout", r5);
        habilitar = 1'b0;
        repeat (20) @(negedge clk);
        echo = 1'b0;
        wait_idle("t4_idle_timeout", t);
        chk("t4_idle_at_period", t - r5, 300);

        // 5: habilitar dropped mid-measurement, 50-cycle echo
        push(1'b1, 20'd50, 2'b11);
        habilitar = 1'b1;
        wait_trig(1'b1, "t5_rise_timeout", r6);
        wait_trig(1'b0, "t5_fall_timeout", f6);
        repeat (3) @(negedge clk);
        echo = 1'b1;
        repeat (10) @(negedge clk);
        habilitar = 1'b0;
        repeat (40) @(negedge clk);
        echo = 1'b0;
        wait_idle("t5_idle_timeout", t);
        chk("t5_idle_at_period", t - r6, 300);
        count_trig(400, h);
        chk("t5_no_retrig", h, 0);

        // 6: reset during MEASURE
        habilitar = 1'b1;
        wait_trig(1'b1, "t6_rise_timeout", t);
        wait_trig(1'b0, "t6_fall_timeout", t);
        repeat (2) @(negedge clk);
        echo = 1'b1;
        repeat (10) @(negedge clk);
        chk("t6_busy_before_reset", {31'd0, ocupado}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("t6_async_reset");
        habilitar = 1'b0;
        repeat (3) @(negedge clk);
        echo = 1'b0;
        rst_n = 1'b1;
        count_trig(30, h);
        chk("t6_no_trig_after_reset", h, 0);

        // 7: reset during TRIGGER drops trig asynchronously
        habilitar = 1'b1;
        wait_trig(1'b1, "t7_rise_timeout", t);
        repeat (2) @(negedge clk);
        chk("t7_trig_high", {31'd0, trig}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t7_trig_async_drop", {31'd0, trig}, 32'd0);
        habilitar = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        count_trig(10, h);
        chk("t7_no_trig_after_reset", h, 0);

        // 8: recovery after reset, 12-cycle echo, code back to 00
        push(1'b1, 20'd12, 2'b00);
        habilitar = 1'b1;
        wait_trig(1'b1, "t8_rise_timeout", t);
        habilitar = 1'b0;
        wait_trig(1'b0, "t8_fall_timeout", t);
        repeat (3) @(negedge clk);
        echo = 1'b1;
        repeat (12) @(negedge clk);
        echo = 1'b0;
        wait_idle("t8_idle_timeout", t);

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
